rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter TMAX, default 15: maximum grant cycles before forced release (timeout build only), 1..2^CW-1.
REQ-003 SHALL have parameter CW, default 4: timeout counter width.
REQ-004 SHALL have port Clock  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port r  input  N  request vector; requester i holds r[i] high for as long as it uses the resource.
REQ-007 SHALL have port g  output  N  registered one-hot grant; all zero when no grant is active.
REQ-008 SHALL have port gid  output  clog2(N)  index of the current or most recent owner.
REQ-009 SHALL have port busy  output  1  high while any g bit is high.
REQ-010 SHALL have port tout  output  1  one-cycle pulse on a forced release.

Function
REQ-011 SHALL implement an FSM with states IDLE, GNT and GAP.
REQ-012 IDLE: if r is nonzero, SHALL select the first i with r[i]=1, searching ptr, ptr+1, ... wrapping modulo N; SHALL go to GNT with g[i]=1 and gid=i from the next edge (1-cycle latency). If r is zero, SHALL stay in IDLE.
REQ-013 GNT: SHALL hold g unchanged while r[gid]=1; requests from other requesters SHALL NOT preempt.
REQ-014 GNT with r[gid]=0 at the edge: SHALL go to GAP, clear g, and set ptr=(gid+1) mod N.
REQ-015 GAP: SHALL last exactly one cycle with g all zero, then go to IDLE; requests SHALL NOT be evaluated in GAP.
REQ-016 Pointer wrap: gid=N-1 released SHALL set ptr=0.
REQ-017 Requests withdrawn in IDLE before an edge SHALL NOT be granted; arbitration SHALL use only the r value sampled at the edge.
REQ-018 busy SHALL equal the OR of all g bits; gid SHALL hold its value through GAP and IDLE.
REQ-019 No grant SHALL ever be issued to a requester whose r bit was low at the deciding edge.

Reset
REQ-020 Reset high SHALL immediately, without a clock edge, force state=IDLE, g=0, gid=0, ptr=0, busy=0, tout=0, and timeout count=0.
REQ-021 Reset asserted mid-grant SHALL drop g asynchronously; after release, arbitration SHALL restart from ptr=0.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: a CW-bit counter SHALL clear on entry to GNT and increment each GNT cycle, saturating at TMAX.
REQ-023 With ARB_TIMEOUT_EN defined: when count=TMAX, r[gid]=1 and any other r bit is high, SHALL force GAP, clear g, advance ptr as in REQ-014, and pulse tout high for exactly that GAP cycle.
REQ-024 With ARB_TIMEOUT_EN defined: if count=TMAX with no other requester, the grant SHALL persist and tout SHALL stay 0.
REQ-025 With ARB_TIMEOUT_EN defined: if r[gid] drops in the same cycle the timeout fires, the release SHALL be a normal release with tout=0.
REQ-026 Macro ARB_TIMEOUT_EN undefined: no counter SHALL be built, tout SHALL be tied 0, and grants SHALL last until released.

Verification
REQ-027 Reset pulse, then r=0001 -> at the next edge g=0001, gid=0, busy=1; r=0000 -> g=0000 for GAP, then IDLE.
REQ-028 r=1111 held, each owner drops its r for 1 cycle after 3 grant cycles -> grant order 0,1,2,3,0 with one all-zero GAP cycle between grants.
REQ-029 Owner 3 releases, then r=1001 -> g=0001 (ptr wrapped to 0); then with ptr=1 and r=1001 -> g=1000.
REQ-030 ARB_TIMEOUT_EN, TMAX=15, r=0011 held -> g=0001 for 15 cycles, then tout=1 with g=0000 for 1 cycle, then g=0010; without the macro g=0001 indefinitely and tout=0.
REQ-031 Reset asserted between clock edges during g=0100 -> g=0000, busy=0 before the next edge; after release, r=0110 -> g=0010.

Source files
------------

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: IDLE/GNT/GAP FSM with one-hot registered grant and rotating priority.
// Optional forced-release timeout when ARB_TIMEOUT_EN is defined.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int TMAX = 15,
  parameter int CW   = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [N-1:0]         r,
  output logic [N-1:0]         g,
  output logic [$clog2(N)-1:0] gid,
  output logic                 busy,
  output logic                 tout
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, GNT, GAP} state_t;

  state_t        state_q;
  logic [N-1:0]  g_q;
  logic [IW-1:0] gid_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW:0]   pick;
  logic          tmo_fire;

  // Returns {found, index} of the first set request at or after start, wrapping.
  function automatic logic [IW:0] first_from(input logic [N-1:0] req,
                                             input logic [IW-1:0] start);
    logic [IW:0] res;
    int          j;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(start) + k) % N;
      if (req[j]) res = {1'b1, IW'(j)};
    end
    return res;
  endfunction

  assign pick  = first_from(r, ptr_q);
  assign ptr_d = (gid_q == IW'(N - 1)) ? '0 : gid_q + IW'(1);

`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tout_q;

  // cnt_d is the number of grant cycles completed at the end of the current one.
  assign cnt_d    = (cnt_q == CW'(TMAX)) ? cnt_q : cnt_q + CW'(1);
  assign tmo_fire = (cnt_d == CW'(TMAX)) && ((r & ~g_q) != '0);
  assign tout     = tout_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (state_q == GNT) begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign tout     = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      tout_q  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      tout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick[IW]) begin
            state_q <= GNT;
            g_q     <= N'(1) << pick[IW-1:0];
            gid_q   <= pick[IW-1:0];
          end
        end
        GNT: begin
          // A normal release takes precedence over a timeout in the same cycle.
          if (!r[gid_q]) begin
            state_q <= GAP;
            g_q     <= '0;
            ptr_q   <= ptr_d;
          end else if (tmo_fire) begin
            state_q <= GAP;
            g_q     <= '0;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            tout_q  <= 1'b1;
`endif
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          g_q     <= '0;
        end
      endcase
    end
  end

  assign g    = g_q;
  assign gid  = gid_q;
  assign busy = |g_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (N=4): vector table plus hand-written reset,
// withdrawal and timeout sequences, all checked through an expectation queue.
module tb_rr_arbiter;
  logic       Clock;
  logic       Reset;
  logic [3:0] r;
  logic [3:0] g;
  logic [1:0] gid;
  logic       busy;
  logic       tout;

  typedef struct {
    logic [3:0] g;
    logic [1:0] gid;
    logic       busy;
    logic       tout;
    string      name;
  } exp_t;

  typedef struct {
    logic [3:0] r;
    logic [3:0] g;
    logic [1:0] gid;
    logic       busy;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[27];
  int   nvec;
  int   nerr;

  rr_arbiter #(.N(4), .TMAX(15), .CW(4)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .r    (r),
    .g    (g),
    .gid  (gid),
    .busy (busy),
    .tout (tout)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic expect_push(input logic [3:0] eg, input logic [1:0] egid,
                             input logic eb, input logic et, input string nm);
    exp_t e;
    e.g = eg; e.gid = egid; e.busy = eb; e.tout = et; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      nerr++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    nvec++;
    if (g !== e.g || gid !== e.gid || busy !== e.busy || tout !== e.tout) begin
      nerr++;
      $display("FAIL %s @%0t: got g=%b gid=%0d busy=%b tout=%b, want g=%b gid=%0d busy=%b tout=%b",
               e.name, $time, g, gid, busy, tout, e.g, e.gid, e.busy, e.tout);
    end
  endtask

  task automatic drive_cycle(input logic [3:0] rv, input logic [3:0] eg,
                             input logic [1:0] egid, input logic eb,
                             input logic et, input string nm);
    @(negedge Clock);
    r = rv;
    expect_push(eg, egid, eb, et, nm);
    @(posedge Clock);
    #1;
    check_out();
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    r     = 4'b0000;
    Reset = 1'b0;

    // Sequence from reset (ptr=0): single grant, full rotation, wrap, no preemption.
    tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[2]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0010, 2'd1, 1'b1};
    tbl[5]  = '{4'b1111, 4'b0010, 2'd1, 1'b1};
    tbl[6]  = '{4'b1111, 4'b0010, 2'd1, 1'b1};
    tbl[7]  = '{4'b1101, 4'b0000, 2'd1, 1'b0};
    tbl[8]  = '{4'b1111, 4'b0000, 2'd1, 1'b0};
    tbl[9]  = '{4'b1111, 4'b0100, 2'd2, 1'b1};
    tbl[10] = '{4'b1111, 4'b0100, 2'd2, 1'b1};
    tbl[11] = '{4'b1111, 4'b0100, 2'd2, 1'b1};
    tbl[12] = '{4'b1011, 4'b0000, 2'd2, 1'b0};
    tbl[13] = '{4'b1111, 4'b0000, 2'd2, 1'b0};
    tbl[14] = '{4'b1111, 4'b1000, 2'd3, 1'b1};
    tbl[15] = '{4'b1111, 4'b1000, 2'd3, 1'b1};
    tbl[16] = '{4'b1111, 4'b1000, 2'd3, 1'b1};
    tbl[17] = '{4'b0111, 4'b0000, 2'd3, 1'b0};
    tbl[18] = '{4'b1001, 4'b0000, 2'd3, 1'b0};
    tbl[19] = '{4'b1001, 4'b0001, 2'd0, 1'b1};
    tbl[20] = '{4'b1000, 4'b0000, 2'd0, 1'b0};
    tbl[21] = '{4'b1001, 4'b0000, 2'd0, 1'b0};
    tbl[22] = '{4'b1001, 4'b1000, 2'd3, 1'b1};
    tbl[23] = '{4'b1001, 4'b1000, 2'd3, 1'b1};
    tbl[24] = '{4'b0001, 4'b0000, 2'd3, 1'b0};
    tbl[25] = '{4'b0000, 4'b0000, 2'd3, 1'b0};
    tbl[26] = '{4'b0000, 4'b0000, 2'd3, 1'b0};

    // Asynchronous reset before any clock edge.
    #1 Reset = 1'b1;
    #1;
    expect_push(4'b0000, 2'd0, 1'b0, 1'b0, "reset_state");
    check_out();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    for (int i = 0; i < 27; i++)
      drive_cycle(tbl[i].r, tbl[i].g, tbl[i].gid, tbl[i].busy, 1'b0,
                  $sformatf("table[%0d]", i));

    // Request raised and withdrawn between edges must not be granted.
    @(negedge Clock);
    r = 4'b0010;
    #2 r = 4'b0000;
    expect_push(4'b0000, 2'd3, 1'b0, 1'b0, "withdrawn_req");
    @(posedge Clock);
    #1;
    check_out();

    // Reset mid-grant drops g without a clock edge, then arbitration restarts at ptr=0.
    drive_cycle(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "grant_before_reset");
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    expect_push(4'b0000, 2'd0, 1'b0, 1'b0, "async_reset_midgrant");
    check_out();
    @(negedge Clock);
    Reset = 1'b0;
    r = 4'b0000;
    drive_cycle(4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0, "post_reset_ptr0");
    drive_cycle(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "post_reset_gap");
    drive_cycle(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "post_reset_idle");

    // Long hold with a competing requester (ptr=2 -> requester 0 wins).
    for (int i = 0; i < 15; i++)
      drive_cycle(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, $sformatf("hold[%0d]", i));
`ifdef ARB_TIMEOUT_EN
    drive_cycle(4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1, "timeout_gap");
    drive_cycle(4'b0011, 4'b0000, 2'd0, 1'b0, 1'b0, "timeout_idle");
    drive_cycle(4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0, "timeout_next_owner");
    for (int i = 0; i < 20; i++)
      drive_cycle(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, $sformatf("sole_persist[%0d]", i));
`else
    for (int i = 0; i < 20; i++)
      drive_cycle(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, $sformatf("no_timeout[%0d]", i));
`endif

    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_leftover: %0d expectations never checked, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
